// File: rtl/fir_param_stream.sv
// Streaming direct-form FIR filter. The pipeline has three stages: delay line, registered
// products, and a registered sum with width conversion. The output handshake drives one global stall.
module fir_param_stream #(
    parameter int DATA_W = 17,
    parameter int COEF_W = 16,
    parameter int TAPS   = 16,
    parameter int OUT_W  = 40,
    parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic                     clock95,
    input  logic                     reset95_n,
    input  logic                     clear,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     coef_wr,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_valid,
    input  logic                     out_ready
);
    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [COEF_W-1:0] coef   [TAPS];
    logic signed [DATA_W-1:0] taps_x [TAPS];
    logic signed [PROD_W-1:0] prod   [TAPS];
    logic                     x_valid;
    logic                     prod_valid;
    logic                     stall;
    logic                     accept;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [OUT_W-1:0]  acc_conv;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall && !clear;
    assign accept   = in_valid && in_ready;

    // NOTE: the coefficient bank is reset because a post-reset filter must produce zeros, not stale taps.
    always_ff @(posedge clock95 or negedge reset95_n) begin
        if (!reset95_n) begin
            for (int i = 0; i < TAPS; i++) coef[i] <= '0;
        end else if (coef_wr && (int'(coef_addr) < TAPS)) begin
            coef[coef_addr] <= coef_data;
        end
    end

    // NOTE: all pipeline state uses non-blocking assignments so every stage samples the previous edge's values.
    always_ff @(posedge clock95 or negedge reset95_n) begin
        if (!reset95_n) begin
            for (int i = 0; i < TAPS; i++) begin
                taps_x[i] <= '0;
                prod[i]   <= '0;
            end
            x_valid    <= 1'b0;
            prod_valid <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else if (clear) begin
            for (int i = 0; i < TAPS; i++) begin
                taps_x[i] <= '0;
                prod[i]   <= '0;
            end
            x_valid    <= 1'b0;
            prod_valid <= 1'b0;
            out_valid  <= 1'b0;
        end else if (!stall) begin
            if (accept) begin
                for (int i = TAPS - 1; i > 0; i--) taps_x[i] <= taps_x[i-1];
                taps_x[0] <= in_data;
            end
            x_valid <= accept;
            for (int i = 0; i < TAPS; i++) prod[i] <= PROD_W'(taps_x[i]) * PROD_W'(coef[i]);
            prod_valid <= x_valid;
            if (prod_valid) out_data <= acc_conv;
            out_valid <= prod_valid;
        end
    end

    // NOTE: blocking accumulation inside always_comb, with a default first so no latch is inferred.
    always_comb begin
        acc_sum = '0;
        for (int i = 0; i < TAPS; i++) acc_sum = acc_sum + ACC_W'(prod[i]);
    end

    generate
        if (OUT_W >= ACC_W) begin : g_extend
            assign acc_conv = OUT_W'(acc_sum);
        end else begin : g_saturate
            localparam int TOP_W = ACC_W - OUT_W + 1;
            logic [TOP_W-1:0] top_bits;
            assign top_bits = acc_sum[ACC_W-1:OUT_W-1];
            // In range only when every discarded bit equals the new sign bit.
            always_comb begin
                if (top_bits == '0 || top_bits == '1) acc_conv = acc_sum[OUT_W-1:0];
                else if (acc_sum[ACC_W-1])            acc_conv = {1'b1, {(OUT_W-1){1'b0}}};
                else                                  acc_conv = {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
    endgenerate

    // A stalled result must stay put until the consumer takes it.
    assert property (@(posedge clock95) disable iff (!reset95_n)
        (stall && !clear) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_fir_param_stream.sv
// Directed bench for fir_param_stream. It drives three parameterisations from one stimulus:
// defaults, OUT_W=24 and TAPS=12.
module tb_fir_param_stream;
    localparam int DATA_W = 17;
    localparam int COEF_W = 16;

    logic                     clock95 = 1'b0;
    logic                     reset95_n;
    logic                     clear;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_valid;
    logic                     coef_wr;
    logic [3:0]               coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     out_ready;

    logic                     a_ready, a_valid;
    logic signed [39:0]       a_out;
    logic                     b_ready, b_valid;
    logic signed [23:0]       b_out;
    logic                     c_ready, c_valid;
    logic signed [39:0]       c_out;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic signed [DATA_W-1:0] din;
        logic                     vin;
        logic                     oready;
        logic                     exp_ready;
        logic                     exp_valid;
        longint                   exp_data;
    } vec_t;

    vec_t tbl[$];

    always #5 clock95 = ~clock95;

    fir_param_stream u_a (
        .clock95(clock95), .reset95_n(reset95_n), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_ready(a_ready),
        .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_data(a_out), .out_valid(a_valid), .out_ready(out_ready)
    );

    fir_param_stream #(.OUT_W(24)) u_b (
        .clock95(clock95), .reset95_n(reset95_n), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_ready(b_ready),
        .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_data(b_out), .out_valid(b_valid), .out_ready(out_ready)
    );

    fir_param_stream #(.TAPS(12)) u_c (
        .clock95(clock95), .reset95_n(reset95_n), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_ready(c_ready),
        .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_data(c_out), .out_valid(c_valid), .out_ready(out_ready)
    );

    task automatic check(input string name, input logic signed [63:0] actual,
                         input logic signed [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock95);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_data   = '0;
        coef_wr   = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic write_coef(input int addr, input int value);
        coef_wr   = 1'b1;
        coef_addr = 4'(addr);
        coef_data = COEF_W'(value);
        tick();
        coef_wr   = 1'b0;
    endtask

    task automatic set_all_coef(input int value);
        for (int i = 0; i < 16; i++) write_coef(i, value);
    endtask

    function automatic void add_vec(input int din, input int vin, input int oready,
                                    input int erdy, input int evld, input longint edata);
        vec_t v;
        v.din       = DATA_W'(din);
        v.vin       = (vin != 0);
        v.oready    = (oready != 0);
        v.exp_ready = (erdy != 0);
        v.exp_valid = (evld != 0);
        v.exp_data  = edata;
        tbl.push_back(v);
    endfunction

    task automatic run_table(input string tag);
        foreach (tbl[j]) begin
            in_data   = tbl[j].din;
            in_valid  = tbl[j].vin;
            out_ready = tbl[j].oready;
            #1;
            check($sformatf("%s[%0d].in_ready", tag, j), 64'(a_ready), 64'(tbl[j].exp_ready));
            tick();
            check($sformatf("%s[%0d].out_valid", tag, j), 64'(a_valid), 64'(tbl[j].exp_valid));
            if (tbl[j].exp_valid)
                check($sformatf("%s[%0d].out_data", tag, j), 64'(a_out), tbl[j].exp_data);
        end
        tbl.delete();
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset95_n = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        idle();
        #12;
        check("reset.out_valid", 64'(a_valid), 64'd0);
        check("reset.out_data", 64'(a_out), 64'sd0);
        check("reset.in_ready", 64'(a_ready), 64'd1);
        @(posedge clock95);
        #1;
        reset95_n = 1'b1;

        // Impulse response with c[i] = i+1.
        for (int i = 0; i < 16; i++) write_coef(i, i + 1);
        for (int j = 0; j < 21; j++)
            add_vec((j == 0) ? 1 : 0, 1, 1, 1, (j >= 2) ? 1 : 0,
                    longint'((j >= 2 && j <= 17) ? j - 1 : 0));
        add_vec(0, 0, 1, 1, 1, 0);
        add_vec(0, 0, 1, 1, 1, 0);
        add_vec(0, 0, 1, 1, 0, 0);
        run_table("impulse");

        // Backpressure: constant 100, all taps 1, out_ready low for cycles 10..14.
        set_all_coef(1);
        for (int j = 0; j < 26; j++) begin
            int rdy;
            int exp;
            rdy = (j < 10 || j >= 15) ? 1 : 0;
            if (j < 10)      exp = 100 * (j - 1);
            else if (j < 15) exp = 800;
            else             exp = 100 * ((j - 6 < 16) ? j - 6 : 16);
            add_vec(100, 1, rdy, rdy, (j >= 2) ? 1 : 0, longint'(exp));
        end
        add_vec(0, 0, 1, 1, 1, 1600);
        add_vec(0, 0, 1, 1, 1, 1600);
        add_vec(0, 0, 1, 1, 0, 0);
        run_table("backpressure");

        // Clear mid-ramp, together with a write of c[1] = 3.
        for (int t = 0; t < 6; t++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(t + 1);
            tick();
        end
        clear     = 1'b1;
        in_data   = DATA_W'(999);
        coef_wr   = 1'b1;
        coef_addr = 4'd1;
        coef_data = 16'sd3;
        #1;
        check("clear.in_ready", 64'(a_ready), 64'd0);
        tick();
        check("clear.out_valid_e", 64'(a_valid), 64'd0);
        clear   = 1'b0;
        coef_wr = 1'b0;
        in_data = DATA_W'(7);
        tick();
        check("clear.out_valid_e1", 64'(a_valid), 64'd0);
        in_data = '0;
        tick();
        check("clear.out_valid_e2", 64'(a_valid), 64'd0);
        in_valid = 1'b0;
        tick();
        check("clear.first_valid", 64'(a_valid), 64'd1);
        check("clear.first_data", 64'(a_out), 64'sd7);
        tick();
        check("clear.second_data", 64'(a_out), 64'sd21);
        tick();
        check("clear.bubble", 64'(a_valid), 64'd0);

        // Coefficient update mid-stream, then out-of-range writes on the TAPS=12 instance.
        set_all_coef(1);
        in_valid = 1'b1;
        in_data  = DATA_W'(10);
        repeat (20) tick();
        check("coef.steady_a", 64'(a_out), 64'sd160);
        check("coef.steady_b", 64'(b_out), 64'sd160);
        check("coef.steady_c", 64'(c_out), 64'sd120);
        coef_wr   = 1'b1;
        coef_addr = 4'd0;
        coef_data = 16'sd5;
        tick();
        coef_wr = 1'b0;
        check("coef.edge_k", 64'(a_out), 64'sd160);
        tick();
        check("coef.edge_k1", 64'(a_out), 64'sd160);
        tick();
        check("coef.edge_k2", 64'(a_out), 64'sd200);
        check("coef.c_new", 64'(c_out), 64'sd160);
        coef_wr   = 1'b1;
        coef_addr = 4'd12;
        coef_data = 16'sd77;
        tick();
        coef_addr = 4'd15;
        tick();
        coef_wr = 1'b0;
        repeat (3) tick();
        check("coef.oob_valid", 64'(c_valid), 64'd1);
        check("coef.oob_data", 64'(c_out), 64'sd160);

        // Saturation (OUT_W=24) and full-width sign extension (defaults).
        idle();
        set_all_coef(32767);
        in_valid = 1'b1;
        in_data  = -DATA_W'(65536);
        repeat (20) tick();
        check("sat.neg_b", 64'(b_out), -64'sd8388608);
        check("sat.neg_a", 64'(a_out), -64'sd34358689792);
        in_data = DATA_W'(65535);
        repeat (20) tick();
        check("sat.pos_b", 64'(b_out), 64'sd8388607);
        check("sat.pos_a", 64'(a_out), 64'sd34358165520);

        // Reset mid-stream: in-flight results are discarded and coefficients return to 0.
        in_data = DATA_W'(50);
        repeat (3) tick();
        reset95_n = 1'b0;
        #1;
        check("rst.out_valid", 64'(a_valid), 64'd0);
        check("rst.out_data", 64'(a_out), 64'sd0);
        check("rst.out_data_b", 64'(b_out), 64'sd0);
        check("rst.in_ready", 64'(a_ready), 64'd1);
        tick();
        reset95_n = 1'b1;
        tick();
        check("rst.r1", 64'(a_valid), 64'd0);
        in_valid = 1'b0;
        tick();
        check("rst.r2", 64'(a_valid), 64'd0);
        tick();
        check("rst.first_valid", 64'(a_valid), 64'd1);
        check("rst.first_data", 64'(a_out), 64'sd0);
        tick();
        check("rst.bubble", 64'(a_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
